// File: rtl/l2_bus_bridge.sv
// l2_bus_bridge: serializes one L2 block request into single-word transfers
// on a generic memory bus and reassembles read words into l2load.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | l2state=FREE, waiting for exactly one of l2REN/l2WEN
// XFER  | l2state=BUSY, strobing word w at base + 4*w
// DONE  | l2state=ACCESS for one cycle, block finished
// FAIL  | l2state=ERROR for one cycle (bus error, timeout, or both enables)
module l2_bus_bridge #(
  parameter  int BLOCK_SIZE = 2,
  parameter  int TIMEOUT    = 256,
  localparam int DATA_WIDTH = 32 * BLOCK_SIZE
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  l2REN,
  input  logic                  l2WEN,
  input  logic [31:0]           l2addr,
  input  logic [DATA_WIDTH-1:0] l2store,
  output logic [DATA_WIDTH-1:0] l2load,
  output logic [1:0]            l2state,
  output logic [31:0]           mem_addr,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_byte_en,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_busy,
  input  logic                  mem_error
);

  localparam int WW   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int OFFB = $clog2(4 * BLOCK_SIZE);

  localparam logic [1:0] L2_FREE   = 2'd0;
  localparam logic [1:0] L2_BUSY   = 2'd1;
  localparam logic [1:0] L2_ACCESS = 2'd2;
  localparam logic [1:0] L2_ERROR  = 2'd3;

  localparam logic [31:0]   BLK_MASK  = ~((32'd1 << OFFB) - 32'd1);
  localparam logic [WW-1:0] LAST_WORD = WW'(BLOCK_SIZE - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  op_wr_q, op_wr_d;
  logic [31:0]           base_q, base_d;
  logic [DATA_WIDTH-1:0] store_q, store_d;
  logic [DATA_WIDTH-1:0] load_q, load_d;
  logic [WW-1:0]         w_q, w_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;

  logic                  xfer;
  logic [31:0]           word_sel;

  // State and datapath registers; reset clears everything so no partial
  // transfer can resume.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      base_q  <= '0;
      store_q <= '0;
      load_q  <= '0;
      w_q     <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      base_q  <= base_d;
      store_q <= store_d;
      load_q  <= load_d;
      w_q     <= w_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next-state and datapath updates; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    base_d  = base_q;
    store_d = store_q;
    load_d  = load_q;
    w_d     = w_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (l2REN ^ l2WEN) begin
          op_wr_d = l2WEN;
          base_d  = l2addr & BLK_MASK;
          if (l2WEN) store_d = l2store;
          w_d     = '0;
          tcnt_d  = '0;
          state_d = S_XFER;
        end else if (l2REN && l2WEN) begin
          state_d = S_FAIL;
        end
      end
      S_XFER: begin
        // A strobe is always high here, so mem_error is live; it beats completion.
        if (mem_error) begin
          state_d = S_FAIL;
        end else if (!mem_busy) begin
          if (!op_wr_q) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
              if (w_q == WW'(i)) load_d[32*i +: 32] = mem_rdata;
            end
          end
          tcnt_d = '0;
          if (w_q == LAST_WORD) state_d = S_DONE;
          else                  w_d     = w_q + WW'(1);
        end else if (tcnt_q >= TMO_LAST) begin
          state_d = S_FAIL;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Select the latched store word for the current index.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (w_q == WW'(i)) word_sel = store_q[32*i +: 32];
    end
  end

  // Outputs decoded from registered state only; bus fields are zeroed outside XFER.
  always_comb begin
    xfer        = (state_q == S_XFER);
    mem_ren     = xfer && !op_wr_q;
    mem_wen     = xfer && op_wr_q;
    mem_byte_en = xfer ? 4'hF : 4'h0;
    mem_addr    = xfer ? (base_q + (32'(w_q) << 2)) : 32'd0;
    mem_wdata   = (xfer && op_wr_q) ? word_sel : 32'd0;
    l2load      = load_q;
    case (state_q)
      S_IDLE:  l2state = L2_FREE;
      S_XFER:  l2state = L2_BUSY;
      S_DONE:  l2state = L2_ACCESS;
      S_FAIL:  l2state = L2_ERROR;
      default: l2state = L2_FREE;
    endcase
  end

endmodule

// File: tb/tb_l2_bus_bridge.sv
// Bench for l2_bus_bridge: each block request is expanded into a per-cycle
// schedule of memory responses and expected outputs, then replayed.
module tb_l2_bus_bridge;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        l2REN, l2WEN;
  logic [31:0] l2addr;
  logic [63:0] l2store;
  logic [63:0] l2load;
  logic [1:0]  l2state;
  logic [31:0] mem_addr;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_busy, mem_error;

  l2_bus_bridge #(.BLOCK_SIZE(2), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST), .l2REN(l2REN), .l2WEN(l2WEN), .l2addr(l2addr),
    .l2store(l2store), .l2load(l2load), .l2state(l2state), .mem_addr(mem_addr),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .mem_error(mem_error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren, wen;
    logic [31:0] addr;
    logic [63:0] store;
    logic        busy, err;
    logic [31:0] rdata;
    logic [1:0]  e_state;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_wdata;
    logic [63:0] e_load;
  } ent_t;

  ent_t        plan[$];
  logic [63:0] model_load;

  logic        exp_valid;
  logic [1:0]  exp_state;
  logic        exp_ren, exp_wen;
  logic [31:0] exp_addr, exp_wdata;
  logic [63:0] exp_load;
  int          cur_idx;
  int          obs_done;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t idle_ent();
    ent_t e;
    e.ren = 1'b0; e.wen = 1'b0; e.addr = '0; e.store = '0;
    e.busy = 1'b1; e.err = 1'b1; e.rdata = 32'hBADBAD00;
    e.e_state = 2'd0; e.e_ren = 1'b0; e.e_wen = 1'b0;
    e.e_addr = '0; e.e_wdata = '0; e.e_load = model_load;
    return e;
  endfunction

  // Expand one request into its cycle-by-cycle schedule.
  task automatic plan_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [63:0] store, input int b0, input int b1,
                         input int err_word, input logic [31:0] rd0,
                         input logic [31:0] rd1, input logic drop);
    ent_t        e;
    logic [31:0] base;
    logic [31:0] rw;
    int          nb;
    logic        failed;
    base = {addr[31:3], 3'b000};
    e = idle_ent();
    e.ren = rd; e.wen = wr; e.addr = addr; e.store = store;
    plan.push_back(e);
    if (rd && wr) begin
      e = idle_ent(); e.e_state = 2'd3; plan.push_back(e);
      e = idle_ent(); plan.push_back(e);
      return;
    end
    failed = 1'b0;
    for (int w = 0; w < 2 && !failed; w++) begin
      nb = (w == 0) ? b0 : b1;
      rw = (w == 0) ? rd0 : rd1;
      e = idle_ent();
      e.ren = drop ? 1'b0 : rd; e.wen = drop ? 1'b0 : wr;
      e.addr = ~addr; e.store = ~store;
      e.e_state = 2'd1; e.e_ren = rd; e.e_wen = wr;
      e.e_addr = base + 32'(4 * w);
      e.e_wdata = wr ? store[32*w +: 32] : 32'd0;
      e.busy = 1'b1; e.err = 1'b0;
      for (int k = 0; k < nb && k < TMO; k++) plan.push_back(e);
      if (nb >= TMO) begin
        failed = 1'b1;
      end else if (err_word == w) begin
        e.busy = 1'b0; e.err = 1'b1;
        plan.push_back(e);
        failed = 1'b1;
      end else begin
        e.busy = 1'b0; e.err = 1'b0; e.rdata = rw;
        plan.push_back(e);
        if (rd) model_load[32*w +: 32] = rw;
      end
    end
    e = idle_ent(); e.e_state = failed ? 2'd3 : 2'd2; plan.push_back(e);
    e = idle_ent(); plan.push_back(e);
  endtask

  task automatic set_idle_exp();
    l2REN = 0; l2WEN = 0; l2addr = '0; l2store = '0;
    mem_busy = 0; mem_error = 0; mem_rdata = '0;
    exp_state = 2'd0; exp_ren = 0; exp_wen = 0;
    exp_addr = '0; exp_wdata = '0; exp_load = model_load;
  endtask

  task automatic run_n(input int n);
    ent_t e;
    obs_done = -1;
    for (int i = 0; i < n && plan.size() > 0; i++) begin
      @(posedge CLK); #1;
      e = plan.pop_front();
      l2REN = e.ren; l2WEN = e.wen; l2addr = e.addr; l2store = e.store;
      mem_busy = e.busy; mem_error = e.err; mem_rdata = e.rdata;
      exp_state = e.e_state; exp_ren = e.e_ren; exp_wen = e.e_wen;
      exp_addr = e.e_addr; exp_wdata = e.e_wdata; exp_load = e.e_load;
      cur_idx = i;
      exp_valid = 1'b1;
    end
    @(negedge CLK); #1;
  endtask

  // Per-cycle compare against the schedule.
  always @(negedge CLK) begin
    if (exp_valid) begin
      chk("l2state", 64'(l2state), 64'(exp_state));
      chk("mem_ren", 64'(mem_ren), 64'(exp_ren));
      chk("mem_wen", 64'(mem_wen), 64'(exp_wen));
      chk("mem_byte_en", 64'(mem_byte_en), (exp_ren || exp_wen) ? 64'hF : 64'h0);
      if (exp_ren || exp_wen) begin
        chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
        if (exp_wen) chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
      end
      chk("l2load", l2load, exp_load);
      if ((l2state == 2'd2 || l2state == 2'd3) && obs_done < 0) obs_done = cur_idx;
    end
  end

  initial begin
    nRST = 1'b0;
    exp_valid = 1'b0;
    model_load = '0;
    cur_idx = 0;
    obs_done = -1;
    set_idle_exp();
    #12;
    chk("rst_state", 64'(l2state), 64'd0);
    chk("rst_strobes", 64'({mem_ren, mem_wen}), 64'd0);
    chk("rst_byte_en", 64'(mem_byte_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_load", l2load, 64'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // zero-wait read, unaligned address
    plan_op(1, 0, 32'h0000_1004, 64'h0, 0, 0, -1, 32'h1111_1111, 32'h2222_2222, 0);
    run_n(1000);
    chk("rd_done_cycle", 64'(obs_done), 64'd3);
    chk("rd_load_lit", l2load, 64'h2222_2222_1111_1111);

    // write with 3 busy cycles on word 0, request dropped mid-transfer
    plan_op(0, 1, 32'h0000_2000, 64'hDEAD_BEEF_CAFE_F00D, 3, 0, -1,
            32'h5A5A_5A5A, 32'hA5A5_A5A5, 1);
    run_n(1000);
    chk("wr_done_cycle", 64'(obs_done), 64'd6);
    chk("wr_load_lit", l2load, 64'h2222_2222_1111_1111);

    // read stuck busy: timeout after TMO strobe cycles, then a normal read
    plan_op(1, 0, 32'h0000_4000, 64'h0, 9, 0, -1, 32'h0, 32'h0, 0);
    run_n(1000);
    chk("tmo_done_cycle", 64'(obs_done), 64'd5);
    plan_op(1, 0, 32'h0000_4008, 64'h0, 0, 2, -1, 32'hAAAA_5555, 32'h1234_5678, 0);
    run_n(1000);
    chk("after_tmo_done_cycle", 64'(obs_done), 64'd5);
    chk("after_tmo_load_lit", l2load, 64'h1234_5678_AAAA_5555);

    // both enables high
    plan_op(1, 1, 32'h0000_7000, 64'h1, 0, 0, -1, 32'h0, 32'h0, 0);
    run_n(1000);
    chk("both_done_cycle", 64'(obs_done), 64'd1);

    // bus error on word 1 of a read
    plan_op(1, 0, 32'h0000_5000, 64'h0, 0, 1, 1, 32'h0BAD_F00D, 32'h7777_7777, 0);
    run_n(1000);
    chk("err_done_cycle", 64'(obs_done), 64'd4);
    chk("err_load_lit", l2load, 64'h1234_5678_0BAD_F00D);

    // reset during word 1 of a write
    plan_op(0, 1, 32'h0000_3000, 64'h0123_4567_89AB_CDEF, 0, 5, -1,
            32'h0, 32'h0, 0);
    run_n(3);
    chk("pre_rst_wen", 64'(mem_wen), 64'd1);
    chk("pre_rst_addr", 64'(mem_addr), 64'h3004);
    nRST = 1'b0;
    plan.delete();
    model_load = '0;
    set_idle_exp();
    #1;
    chk("midrst_strobes", 64'({mem_ren, mem_wen}), 64'd0);
    chk("midrst_byte_en", 64'(mem_byte_en), 64'd0);
    chk("midrst_state", 64'(l2state), 64'd0);
    chk("midrst_load", l2load, 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    plan_op(1, 0, 32'h0000_6000, 64'h0, 0, 0, -1, 32'hFEED_FACE, 32'h0C0F_FEE0, 0);
    run_n(1000);
    chk("post_rst_done_cycle", 64'(obs_done), 64'd3);
    chk("post_rst_load_lit", l2load, 64'h0C0F_FEE0_FEED_FACE);

    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_bus_bridge.md
# l2_bus_bridge

Memory-side bridge directly downstream of the coherence bus controller's L2 port. Accepts one block-wide L2 read or write request (l2REN/l2WEN, l2addr, l2store) and reports progress on the 2-bit l2state (FREE/BUSY/ACCESS/ERROR). Each block is serialized into BLOCK_SIZE 32-bit word transfers on a generic single-word memory bus, and read words are reassembled into l2load. It is the real replacement for the dummy L2 model used in testbenches.

## Interface
- BLOCK_SIZE, 2: words per block; DATA_WIDTH = 32*BLOCK_SIZE.
- TIMEOUT, 256: maximum consecutive mem_busy cycles per word before the bridge reports ERROR; must be ≥1.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- l2REN  in  1  block read request, held by the bus controller until ACCESS or ERROR.
- l2WEN  in  1  block write request, held by the bus controller until ACCESS or ERROR.
- l2addr  in  32  request address; the low log2(4*BLOCK_SIZE) bits are ignored (block-aligned).
- l2store  in  DATA_WIDTH  write block; word i is bits [32i+31:32i].
- l2load  out  DATA_WIDTH  read block; valid while l2state==ACCESS after a read.
- l2state  out  2  L2_FREE=0, L2_BUSY=1, L2_ACCESS=2, L2_ERROR=3.
- mem_addr  out  32  word address.
- mem_ren  out  1  word read strobe.
- mem_wen  out  1  word write strobe.
- mem_wdata  out  32  write word.
- mem_byte_en  out  4  byte enables; 4'hF whenever a strobe is high, otherwise 0.
- mem_rdata  in  32  read word, sampled in the completing cycle.
- mem_busy  in  1  a word completes in any cycle where a strobe is high and mem_busy==0.
- mem_error  in  1  bus error; sampled only while a strobe is high.

## Operation
- FSM states: IDLE, XFER, DONE, FAIL.
- IDLE:
  - l2state=FREE; all mem strobes are low.
  - If exactly one of l2REN or l2WEN is high: latch base = block-aligned l2addr, latch op, latch l2store (writes), clear word index w and the timeout counter, then go to XFER.
  - If both are high: go to FAIL. No memory access is issued.
- XFER:
  - l2state=BUSY.
  - mem_addr = base + 4*w.
  - mem_ren = op==read; mem_wen = op==write.
  - mem_wdata = latched word w.
- XFER, word completes (strobe high, mem_busy==0, mem_error==0):
  - Reads capture mem_rdata into l2load word w.
  - Clear the timeout counter.
  - If w==BLOCK_SIZE-1, go to DONE; otherwise increment w.
- XFER, mem_error==1 while a strobe is high: go to FAIL. mem_error takes priority over completion in the same cycle.
- XFER, mem_busy==1: increment the timeout counter. When it reaches TIMEOUT-1 while still busy, go to FAIL.
- DONE: l2state=ACCESS for exactly one cycle, then IDLE.
- FAIL: l2state=ERROR for exactly one cycle, then IDLE.
- l2load:
  - Updated only by read word captures.
  - Holds its value across writes, errors and IDLE.
  - After an errored read, l2load contains the words captured before the error; the other words are unchanged.
- Requests are sampled only in IDLE. Changes to l2addr or l2store during XFER have no effect.
- Dropping l2REN/l2WEN mid-transfer does not abort the transfer; the block still completes.
- Width rules:
  - w is max(1,$clog2(BLOCK_SIZE)) bits.
  - The timeout counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.
  - Address increments are modulo 2^32.

## Timing
- Reset (asynchronous, immediate, including mid-transfer):
  - State returns to IDLE; l2state=FREE.
  - l2load=0, mem_addr=0, mem_wdata=0, mem_ren=0, mem_wen=0, mem_byte_en=0.
  - No partial transfer resumes after reset.
- All outputs are decoded from registered state only; none depends combinationally on bus-controller inputs.
- Zero-wait memory: request sampled at edge 0 → strobes for word 0 in cycle 1 → word 1 in cycle 2 → ACCESS in cycle 3 (BLOCK_SIZE+1 cycles from sampling edge to ACCESS).
- Each busy cycle adds one cycle.
- A word with continuous mem_busy reaches FAIL after TIMEOUT strobe cycles.
- At least one FREE cycle follows every ACCESS/ERROR before the next request is sampled.
- Strobes are never high in IDLE, DONE or FAIL.
- mem_addr and mem_wdata are stable for every cycle a strobe is high.

## Test plan
- Read, zero-wait, l2addr=0x0000_1004, mem_rdata returns 0x1111_1111 then 0x2222_2222 → mem_addr 0x1000 then 0x1004, l2state BUSY,BUSY,ACCESS, l2load=0x2222_2222_1111_1111.
- Write, l2addr=0x2000, l2store=0xDEAD_BEEF_CAFE_F00D, mem_busy=1 for 3 cycles on word 0 → mem_wdata 0xCAFE_F00D held 4 cycles, then 0xDEAD_BEEF at 0x2004, ACCESS at cycle 6; l2load unchanged.
- TIMEOUT=4, read with mem_busy stuck high → ERROR after 4 strobe cycles, then FREE with strobes low; the next read completes normally.
- l2REN and l2WEN high together → one BUSY-free cycle then ERROR, with no mem strobe ever asserted.
- mem_error on word 1 of a read → ERROR; l2load word 0 updated, word 1 unchanged.
- nRST low during word 1 of a write → strobes drop in the same cycle, l2state FREE, l2load=0; after release the bridge accepts a new read.
